// File: rtl/bas_multistart_sched.sv
// Multi-start scheduler for the bas beetle-antennae-search core.
// Runs the core NUM_RUNS times from a lattice of start points and per-run
// seeds, guards each run with a timeout and keeps the global best result.
module bas_multistart_sched #(
    parameter int unsigned NUM_RUNS       = 8,
    parameter logic [8:0]  SEED_STEP      = 9'd37,
    parameter int unsigned TIMEOUT_MARGIN = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [8:0]         iterations,
    input  logic [8:0]         seed_x_base,
    input  logic [8:0]         seed_y_base,
    input  logic signed [15:0] x_base,
    input  logic signed [15:0] y_base,
    input  logic signed [15:0] x_step,
    input  logic signed [15:0] y_step,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic signed [15:0] best_x,
    output logic signed [15:0] best_y,
    output logic signed [39:0] best_value,
    output logic [7:0]         best_run,
    output logic [7:0]         runs_done,
    output logic               core_reset,
    output logic               core_load,
    output logic [8:0]         core_seed_x,
    output logic [8:0]         core_seed_y,
    output logic [8:0]         core_iterations,
    output logic signed [15:0] core_x,
    output logic signed [15:0] core_y,
    input  logic               core_done,
    input  logic signed [15:0] core_x_extreme,
    input  logic signed [15:0] core_y_extreme,
    input  logic signed [39:0] core_out_value
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_CMP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [7:0]  LAST_RUN = 8'(NUM_RUNS - 1);
    localparam logic [10:0] MARGIN_W = 11'(TIMEOUT_MARGIN);

    // A zero seed would lock the core's LFSR, so it is replaced by 1.
    function automatic logic [8:0] seed_guard(input logic [8:0] s);
        logic [8:0] r;
        if (s == 9'd0) begin
            r = 9'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

    state_t state_q, state_d;

    logic [8:0]         iter_q, iter_d;
    logic signed [15:0] step_x_q, step_x_d, step_y_q, step_y_d;
    logic signed [15:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [8:0]         sx_acc_q, sx_acc_d, sy_acc_q, sy_acc_d;
    logic [7:0]         run_q, run_d;
    logic [10:0]        tcnt_q, tcnt_d;
    logic               skip_q, skip_d;
    logic signed [15:0] best_x_q, best_x_d, best_y_q, best_y_d;
    logic signed [39:0] best_value_q, best_value_d;
    logic [7:0]         best_run_q, best_run_d;
    logic [7:0]         runs_done_q, runs_done_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               core_reset_q, core_reset_d;
    logic               core_load_q, core_load_d;
    logic signed [15:0] core_x_q, core_x_d, core_y_q, core_y_d;
    logic [8:0]         core_sx_q, core_sx_d, core_sy_q, core_sy_d;

    logic [10:0]        limit_s;
    logic               timeout_s;
    logic               accept_s;

    assign limit_s  = {2'b00, iter_q} + MARGIN_W;
    assign accept_s = (state_q == S_IDLE) && start;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; core_done has priority over the timeout.
    always_comb begin
        state_d   = state_q;
        timeout_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST:  state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (core_done) begin
                    state_d = S_CMP;
                end else if (tcnt_q == limit_s) begin
                    state_d   = S_CMP;
                    timeout_s = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_CMP: begin
                if (run_q == LAST_RUN) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RST;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs, decoded from the next state so the registered copies line up with the state.
    always_comb begin
        busy_d       = 1'b1;
        done_d       = 1'b0;
        core_reset_d = 1'b0;
        core_load_d  = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d       = 1'b0;
                core_reset_d = 1'b1;
            end
            S_RST:   core_reset_d = 1'b1;
            S_LOAD:  core_load_d  = 1'b1;
            S_RUN:   core_load_d  = 1'b0;
            S_CMP:   core_load_d  = 1'b0;
            S_FIN:   done_d       = 1'b1;
            default: busy_d       = 1'b0;
        endcase
    end

    // Datapath: config latch, start-point/seed accumulators, timeout counter, best tracking.
    always_comb begin
        iter_d       = iter_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        sx_acc_d     = sx_acc_q;
        sy_acc_d     = sy_acc_q;
        run_d        = run_q;
        tcnt_d       = tcnt_q;
        skip_d       = skip_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        best_value_d = best_value_q;
        best_run_d   = best_run_q;
        runs_done_d  = runs_done_q;
        error_d      = error_q;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_sx_d    = core_sx_q;
        core_sy_d    = core_sy_q;

        if (accept_s) begin
            iter_d       = iterations;
            step_x_d     = x_step;
            step_y_d     = y_step;
            pos_x_d      = x_base;
            pos_y_d      = y_base;
            sx_acc_d     = seed_x_base;
            sy_acc_d     = seed_y_base;
            run_d        = 8'd0;
            best_value_d = 40'sh7FFFFFFFFF;
            best_x_d     = 16'sd0;
            best_y_d     = 16'sd0;
            best_run_d   = 8'd0;
            runs_done_d  = 8'd0;
            error_d      = 1'b0;
        end else if (state_q == S_LOAD) begin
            tcnt_d = 11'd0;
            skip_d = 1'b0;
        end else if (state_q == S_RUN) begin
            tcnt_d = tcnt_q + 11'd1;
            if (timeout_s) begin
                error_d = 1'b1;
                skip_d  = 1'b1;
            end else begin
                skip_d = 1'b0;
            end
        end else if (state_q == S_CMP) begin
            // Strict less-than: on a tie the earlier run stays best.
            if (!skip_q && (core_out_value < best_value_q)) begin
                best_value_d = core_out_value;
                best_x_d     = core_x_extreme;
                best_y_d     = core_y_extreme;
                best_run_d   = run_q;
            end else begin
                best_value_d = best_value_q;
            end
            runs_done_d = runs_done_q + 8'd1;
            if (run_q != LAST_RUN) begin
                run_d    = run_q + 8'd1;
                pos_x_d  = pos_x_q + step_x_q;
                pos_y_d  = pos_y_q + step_y_q;
                sx_acc_d = sx_acc_q + SEED_STEP;
                sy_acc_d = sy_acc_q + SEED_STEP;
            end else begin
                run_d = run_q;
            end
        end else begin
            tcnt_d = tcnt_q;
        end

        // Core configuration is refreshed only on entry to RST and then held.
        if (state_d == S_RST) begin
            core_x_d  = pos_x_d;
            core_y_d  = pos_y_d;
            core_sx_d = seed_guard(sx_acc_d);
            core_sy_d = seed_guard(sy_acc_d);
        end else begin
            core_x_d = core_x_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            iter_q       <= 9'd0;
            step_x_q     <= 16'sd0;
            step_y_q     <= 16'sd0;
            pos_x_q      <= 16'sd0;
            pos_y_q      <= 16'sd0;
            sx_acc_q     <= 9'd1;
            sy_acc_q     <= 9'd1;
            run_q        <= 8'd0;
            tcnt_q       <= 11'd0;
            skip_q       <= 1'b0;
            best_x_q     <= 16'sd0;
            best_y_q     <= 16'sd0;
            best_value_q <= 40'sd0;
            best_run_q   <= 8'd0;
            runs_done_q  <= 8'd0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_reset_q <= 1'b1;
            core_load_q  <= 1'b0;
            core_x_q     <= 16'sd0;
            core_y_q     <= 16'sd0;
            core_sx_q    <= 9'd1;
            core_sy_q    <= 9'd1;
        end else begin
            iter_q       <= iter_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            sx_acc_q     <= sx_acc_d;
            sy_acc_q     <= sy_acc_d;
            run_q        <= run_d;
            tcnt_q       <= tcnt_d;
            skip_q       <= skip_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_value_q <= best_value_d;
            best_run_q   <= best_run_d;
            runs_done_q  <= runs_done_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_reset_q <= core_reset_d;
            core_load_q  <= core_load_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_sx_q    <= core_sx_d;
            core_sy_q    <= core_sy_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign best_x          = best_x_q;
    assign best_y          = best_y_q;
    assign best_value      = best_value_q;
    assign best_run        = best_run_q;
    assign runs_done       = runs_done_q;
    assign core_reset      = core_reset_q;
    assign core_load       = core_load_q;
    assign core_seed_x     = core_sx_q;
    assign core_seed_y     = core_sy_q;
    assign core_iterations = iter_q;
    assign core_x          = core_x_q;
    assign core_y          = core_y_q;

endmodule

// File: tb/tb_bas_multistart_sched.sv
// Bench for bas_multistart_sched: a stub core driven from per-run tables,
// a job-level reference model feeding a scoreboard, and a done monitor.
module tb_bas_multistart_sched;

    localparam int NR     = 4;
    localparam int MARGIN = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [8:0]         iterations, seed_x_base, seed_y_base;
    logic signed [15:0] x_base, y_base, x_step, y_step;
    logic               busy, done, error;
    logic signed [15:0] best_x, best_y;
    logic signed [39:0] best_value;
    logic [7:0]         best_run, runs_done;
    logic               core_reset, core_load;
    logic [8:0]         core_seed_x, core_seed_y, core_iterations;
    logic signed [15:0] core_x, core_y;
    logic               core_done;
    logic signed [15:0] core_x_extreme, core_y_extreme;
    logic signed [39:0] core_out_value;

    bas_multistart_sched #(.NUM_RUNS(NR), .SEED_STEP(9'd37), .TIMEOUT_MARGIN(MARGIN)) dut (
        .clock(clock), .reset(reset), .start(start), .iterations(iterations),
        .seed_x_base(seed_x_base), .seed_y_base(seed_y_base),
        .x_base(x_base), .y_base(y_base), .x_step(x_step), .y_step(y_step),
        .busy(busy), .done(done), .error(error), .best_x(best_x), .best_y(best_y),
        .best_value(best_value), .best_run(best_run), .runs_done(runs_done),
        .core_reset(core_reset), .core_load(core_load),
        .core_seed_x(core_seed_x), .core_seed_y(core_seed_y),
        .core_iterations(core_iterations), .core_x(core_x), .core_y(core_y),
        .core_done(core_done), .core_x_extreme(core_x_extreme),
        .core_y_extreme(core_y_extreme), .core_out_value(core_out_value)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Per-load tables (global load index), filled by the planner.
    logic signed [39:0] tab_val [0:63];
    logic signed [15:0] tab_xe [0:63], tab_ye [0:63], tab_cx [0:63], tab_cy [0:63];
    logic [8:0]         tab_sx [0:63], tab_sy [0:63], tab_it [0:63];
    bit                 tab_hang [0:63];
    int                 load_base = 0;

    // Per-job knobs used by the planner.
    logic signed [39:0] job_val [0:NR-1];
    bit                 job_hang [0:NR-1];

    typedef struct {
        int                 lat;
        int                 acc;
        logic signed [39:0] bv;
        logic signed [15:0] bx, by;
        logic [7:0]         br, rd;
        logic               err;
    } exp_t;

    exp_t exp_q[$];

    // Stub core: done after iterations+2 RUN cycles unless the run is marked hung.
    int stub_ld = 0, stub_cur = 0, stub_cnt = 0;
    bit stub_run = 1'b0;
    always @(posedge clock) begin
        if (core_reset) begin
            stub_run <= 1'b0;
        end else if (core_load) begin
            stub_run <= 1'b1;
            stub_cnt <= 0;
            stub_cur <= stub_ld;
            stub_ld  <= stub_ld + 1;
        end else if (stub_run) begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign core_done      = stub_run && !tab_hang[stub_cur] && (stub_cnt >= int'(tab_it[stub_cur]) + 1);
    assign core_out_value = tab_val[stub_cur];
    assign core_x_extreme = tab_xe[stub_cur];
    assign core_y_extreme = tab_ye[stub_cur];

    // Core configuration seen at each load.
    always @(negedge clock) begin
        if (core_load) begin
            chk("core_x", core_x, tab_cx[stub_ld]);
            chk("core_y", core_y, tab_cy[stub_ld]);
            chk("core_seed_x", core_seed_x, tab_sx[stub_ld]);
            chk("core_seed_y", core_seed_y, tab_sy[stub_ld]);
            chk("core_iterations", core_iterations, tab_it[stub_ld]);
        end
    end

    // Scoreboard monitor: every done pulse is matched against the oldest expected job.
    exp_t mon_e;
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                chk("best_value", best_value, mon_e.bv);
                chk("best_x", best_x, mon_e.bx);
                chk("best_y", best_y, mon_e.by);
                chk("best_run", best_run, mon_e.br);
                chk("runs_done", runs_done, mon_e.rd);
                chk("error", error, mon_e.err);
                chk("busy_at_done", busy, 1'b1);
            end
        end
    end

    // Reference model for one job: drives the config inputs, fills the stub tables, returns the result.
    task automatic plan(input int it, input logic signed [15:0] xb, input logic signed [15:0] yb,
                        input logic signed [15:0] xs, input logic signed [15:0] ys,
                        input logic [8:0] sxb, input logic [8:0] syb, output exp_t e);
        int g, s;
        iterations = 9'(it); x_base = xb; y_base = yb; x_step = xs; y_step = ys;
        seed_x_base = sxb; seed_y_base = syb;
        e.bv = 40'sh7FFFFFFFFF; e.bx = 16'sd0; e.by = 16'sd0; e.br = 8'd0;
        e.rd = 8'(NR); e.err = 1'b0; e.lat = 0; e.acc = 0;
        for (int r = 0; r < NR; r++) begin
            g = load_base + r;
            tab_it[g] = 9'(it);
            tab_cx[g] = 16'(int'(xb) + r * int'(xs));
            tab_cy[g] = 16'(int'(yb) + r * int'(ys));
            s = (int'(sxb) + r * 37) % 512;
            tab_sx[g] = (s == 0) ? 9'd1 : 9'(s);
            s = (int'(syb) + r * 37) % 512;
            tab_sy[g] = (s == 0) ? 9'd1 : 9'(s);
            tab_xe[g] = 16'($urandom);
            tab_ye[g] = 16'($urandom);
            tab_hang[g] = job_hang[r];
            if (job_hang[r]) begin
                tab_val[g] = 40'sh8000000000;
                e.err = 1'b1;
                e.lat += it + MARGIN + 1 + 3;
            end else begin
                tab_val[g] = job_val[r];
                e.lat += it + 2 + 3;
                if (job_val[r] < e.bv) begin
                    e.bv = job_val[r];
                    e.bx = tab_xe[g];
                    e.by = tab_ye[g];
                    e.br = 8'(r);
                end
            end
        end
        load_base += NR;
    endtask

    task automatic pulse_start(output int acc);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic rand_knobs(input bit allow_hang);
        for (int r = 0; r < NR; r++) begin
            job_val[r]  = 40'sd1000 * 40'($urandom_range(0, 5)) - 40'sd2000;
            job_hang[r] = allow_hang && ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_core_load"}, core_load, 1'b0);
        chk({tag, "_core_reset"}, core_reset, 1'b1);
        chk({tag, "_best_x"}, best_x, 16'd0);
        chk({tag, "_best_y"}, best_y, 16'd0);
        chk({tag, "_best_value"}, best_value, 40'd0);
        chk({tag, "_best_run"}, best_run, 8'd0);
        chk({tag, "_runs_done"}, runs_done, 8'd0);
        chk({tag, "_core_x"}, core_x, 16'd0);
        chk({tag, "_core_y"}, core_y, 16'd0);
        chk({tag, "_core_iter"}, core_iterations, 9'd0);
        chk({tag, "_seed_x"}, core_seed_x, 9'd1);
        chk({tag, "_seed_y"}, core_seed_y, 9'd1);
    endtask

    exp_t ea, eb;
    int   acc;

    initial begin
        reset = 1'b1; start = 1'b0; iterations = 9'd0; seed_x_base = 9'd0; seed_y_base = 9'd0;
        x_base = 16'sd0; y_base = 16'sd0; x_step = 16'sd0; y_step = 16'sd0;
        for (int i = 0; i < 64; i++) begin
            tab_val[i] = 40'sd0; tab_xe[i] = 16'sd0; tab_ye[i] = 16'sd0; tab_hang[i] = 1'b0;
            tab_it[i] = 9'd0; tab_cx[i] = 16'sd0; tab_cy[i] = 16'sd0; tab_sx[i] = 9'd1; tab_sy[i] = 9'd1;
        end
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clock);

        // Values 500/200/200/900: tie on 200 keeps run 1.
        job_val[0] = 40'sd500; job_val[1] = 40'sd200; job_val[2] = 40'sd200; job_val[3] = 40'sd900;
        for (int r = 0; r < NR; r++) job_hang[r] = 1'b0;
        plan(20, 16'sh0000, 16'sh0000, 16'sh0100, 16'sh0100, 9'($urandom), 9'($urandom), ea);
        pulse_start(acc); ea.acc = acc; exp_q.push_back(ea);
        repeat (ea.lat + 3) @(negedge clock);

        // Zero iterations, every run returns the same value: run 0 stays best.
        for (int r = 0; r < NR; r++) begin job_val[r] = 40'sh000FFFFFFF; job_hang[r] = 1'b0; end
        plan(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 9'($urandom), 9'($urandom), ea);
        pulse_start(acc); ea.acc = acc; exp_q.push_back(ea);
        repeat (ea.lat + 3) @(negedge clock);

        // Run 2 never finishes: timeout, error, never best despite the lowest value.
        rand_knobs(1'b0); job_hang[2] = 1'b1;
        plan(10, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 9'($urandom), 9'($urandom), ea);
        pulse_start(acc); ea.acc = acc; exp_q.push_back(ea);
        repeat (ea.lat + 3) @(negedge clock);

        // Seed base 0x1DB: run 1 wraps to 0 and must be forced to 1.
        rand_knobs(1'b0);
        plan($urandom_range(1, 40), 16'sh0100, 16'sh0300, 16'($urandom), 16'($urandom), 9'h1DB, 9'h1DB, ea);
        pulse_start(acc); ea.acc = acc; exp_q.push_back(ea);
        repeat (ea.lat + 3) @(negedge clock);

        // Reset during RUN of run 3: aborts to reset state with no done pulse.
        rand_knobs(1'b0);
        plan(15, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 9'($urandom), 9'($urandom), ea);
        pulse_start(acc);
        repeat (3 * (15 + 5) + 5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midjob");
        reset = 1'b0;
        @(negedge clock);

        rand_knobs(1'b1);
        plan($urandom_range(0, 25), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 9'($urandom), 9'($urandom), ea);
        pulse_start(acc); ea.acc = acc; exp_q.push_back(ea);
        repeat (ea.lat + 3) @(negedge clock);

        // Start held high: two back-to-back jobs, the first with timeouts, the second clean.
        rand_knobs(1'b0); job_hang[0] = 1'b1; job_hang[3] = 1'b1;
        plan(6, 16'sh0040, 16'sh0080, 16'sh0010, 16'sh0020, 9'($urandom), 9'($urandom), ea);
        start = 1'b1;
        @(negedge clock);
        ea.acc = cyc; exp_q.push_back(ea);
        rand_knobs(1'b0);
        plan(9, 16'sh0040, 16'sh0080, -16'sh0123, 16'sh0020, 9'($urandom), 9'($urandom), eb);
        eb.acc = ea.acc + ea.lat + 2; exp_q.push_back(eb);
        while (cyc < eb.acc + eb.lat) @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);

        for (int j = 0; j < 3; j++) begin
            rand_knobs(1'b1);
            plan($urandom_range(0, 25), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 9'($urandom), 9'($urandom), ea);
            pulse_start(acc); ea.acc = acc; exp_q.push_back(ea);
            repeat (ea.lat + 3) @(negedge clock);
        end

        repeat (5) @(negedge clock);
        chk("jobs_outstanding", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
